// File: rtl/riscv_cache_pkg.sv
// Shared cache geometry helpers and the miss-handling FSM state type.
package riscv_cache_pkg;

   typedef enum logic [1:0] {
      ARMED,
      WAIT4BIU,
      FILL,
      RECOVER
   } state_t;

   function automatic int no_of_sets(input int size_kb, input int block_size, input int ways);
      return (size_kb * 1024 * 8) / (block_size * ways);
   endfunction

   function automatic int no_of_block_offset_bits(input int block_size);
      return $clog2(block_size / 8);
   endfunction

   function automatic int no_of_index_bits(input int size_kb, input int block_size, input int ways);
      return $clog2(no_of_sets(size_kb, block_size, ways));
   endfunction

   function automatic int no_of_tag_bits(input int plen, input int size_kb, input int block_size,
                                         input int ways);
      return plen - no_of_index_bits(size_kb, block_size, ways) - no_of_block_offset_bits(block_size);
   endfunction

endpackage

// File: rtl/riscv_cache_victim.sv
// Replacement way choice: lowest invalid way, otherwise the round-robin pointer (one-hot out).
module riscv_cache_victim #(
   parameter int WAYS     = 2,
   parameter int PTR_BITS = 1
)(
   input  logic [WAYS-1:0]     i_valid,
   input  logic [PTR_BITS-1:0] i_ptr,
   output logic [WAYS-1:0]     o_way
);

   logic w_found;

   always_comb begin
      o_way   = '0;
      w_found = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!w_found && !i_valid[w]) begin
            o_way[w] = 1'b1;
            w_found  = 1'b1;
         end
      end
      if (!w_found) begin
         for (int w = 0; w < WAYS; w++) begin
            if (PTR_BITS'(w) == i_ptr) o_way[w] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/riscv_cache_hit.sv
// Cache hit/miss stage: tag compare, write-through merge and read-miss line fill.
// Optional feature: define RISCV_CACHE_PERFCNT_EN to add hit_cnt_o / miss_cnt_o.
module riscv_cache_hit
   import riscv_cache_pkg::*;
#(
   parameter  int XLEN       = 32,
   parameter  int PLEN       = XLEN,
   parameter  int SIZE       = 64,
   parameter  int BLOCK_SIZE = 128,
   parameter  int WAYS       = 2,
   localparam int TAG_BITS   = no_of_tag_bits(PLEN, SIZE, BLOCK_SIZE, WAYS),
   localparam int IDX_BITS   = no_of_index_bits(SIZE, BLOCK_SIZE, WAYS)
)(
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       req_i,
   input  logic                       wreq_i,
   input  logic [PLEN-1:0]            adr_i,
   input  logic [XLEN/8-1:0]          be_i,
   input  logic [XLEN-1:0]            d_i,
   input  logic [TAG_BITS-1:0]        core_tag_i,
   input  logic [WAYS*TAG_BITS-1:0]   way_tag_i,
   input  logic [WAYS-1:0]            way_valid_i,
   input  logic [WAYS*BLOCK_SIZE-1:0] way_line_i,
   output logic                       stall_o,
   output logic                       ack_o,
   output logic [XLEN-1:0]            q_o,
   output logic                       biu_stb_o,
   output logic [PLEN-1:0]            biu_adr_o,
   input  logic                       biu_stb_ack_i,
   input  logic                       biu_d_ack_i,
   input  logic [XLEN-1:0]            biu_d_i,
   output logic                       fill_we_o,
   output logic [WAYS-1:0]            fill_way_o,
   output logic [IDX_BITS-1:0]        fill_idx_o,
   output logic [BLOCK_SIZE-1:0]      fill_line_o,
   output logic [TAG_BITS-1:0]        fill_tag_o
`ifdef RISCV_CACHE_PERFCNT_EN
   ,
   output logic [31:0]                hit_cnt_o,
   output logic [31:0]                miss_cnt_o
`endif
);

   localparam int BURST     = BLOCK_SIZE / XLEN;
   localparam int OFF_BITS  = no_of_block_offset_bits(BLOCK_SIZE);
   localparam int BYTE_BITS = $clog2(XLEN / 8);
   localparam int CNT_BITS  = (BURST > 1) ? $clog2(BURST) : 1;
   localparam int PTR_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;

   state_t                       r_state, w_next;
   logic [CNT_BITS-1:0]          r_cnt, r_word;
   logic [PTR_BITS-1:0]          r_rr;
   logic [PLEN-OFF_BITS-1:0]     r_line_adr;
   logic [TAG_BITS-1:0]          r_tag;
   logic [WAYS-1:0]              r_valid;
   logic [BLOCK_SIZE-1:0]        r_buf;
   logic                         r_flushed;

   logic [WAYS-1:0]              w_hit_way, w_hit_sel, w_victim;
   logic                         w_hit, w_take, w_start_miss, w_rd_hit_ack, w_recover_ack;
   logic [CNT_BITS-1:0]          w_word;
   logic [BLOCK_SIZE-1:0]        w_hit_line, w_merge;
   logic [XLEN-1:0]              w_hit_word, w_wr_word;

   logic                         w_stall, w_ack, w_stb, w_fill_we;
   logic [XLEN-1:0]              w_q;
   logic [PLEN-1:0]              w_biu_adr;
   logic [WAYS-1:0]              w_fill_way;
   logic [IDX_BITS-1:0]          w_fill_idx;
   logic [BLOCK_SIZE-1:0]        w_fill_line;
   logic [TAG_BITS-1:0]          w_fill_tag;

   // Descending scan so the lowest-index matching way wins a multi-way hit.
   always_comb begin
      w_hit_way  = '0;
      w_hit_sel  = '0;
      w_hit_line = '0;
      for (int w = 0; w < WAYS; w++) begin
         w_hit_way[w] = way_valid_i[w] && (way_tag_i[w*TAG_BITS +: TAG_BITS] == core_tag_i);
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (w_hit_way[w]) begin
            w_hit_sel    = '0;
            w_hit_sel[w] = 1'b1;
            w_hit_line   = way_line_i[w*BLOCK_SIZE +: BLOCK_SIZE];
         end
      end
   end

   assign w_hit         = req_i & (|w_hit_way);
   assign w_word        = adr_i[OFF_BITS-1:BYTE_BITS];
   assign w_hit_word    = w_hit_line[w_word*XLEN +: XLEN];
   assign w_take        = req_i & ~flush_i;
   assign w_start_miss  = (r_state == ARMED) & w_take & ~wreq_i & ~w_hit;
   assign w_rd_hit_ack  = (r_state == ARMED) & w_take & ~wreq_i & w_hit;
   assign w_recover_ack = (r_state == RECOVER) & ~(r_flushed | flush_i);

   always_comb begin
      w_wr_word = w_hit_word;
      for (int b = 0; b < XLEN / 8; b++) begin
         if (be_i[b]) w_wr_word[b*8 +: 8] = d_i[b*8 +: 8];
      end
      w_merge                        = w_hit_line;
      w_merge[w_word*XLEN +: XLEN]   = w_wr_word;
   end

   riscv_cache_victim #(
      .WAYS     (WAYS),
      .PTR_BITS (PTR_BITS)
   ) u_victim (
      .i_valid (r_valid),
      .i_ptr   (r_rr),
      .o_way   (w_victim)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         ARMED:    if (w_start_miss) w_next = WAIT4BIU;
         WAIT4BIU: if (biu_stb_ack_i) w_next = FILL;
         FILL:     if (biu_d_ack_i && r_cnt == CNT_BITS'(BURST - 1)) w_next = RECOVER;
         RECOVER:  w_next = ARMED;
         default:  w_next = ARMED;
      endcase
   end

   always_comb begin
      w_stall     = 1'b0;
      w_ack       = 1'b0;
      w_q         = '0;
      w_stb       = 1'b0;
      w_biu_adr   = '0;
      w_fill_we   = 1'b0;
      w_fill_way  = '0;
      w_fill_idx  = '0;
      w_fill_line = '0;
      w_fill_tag  = '0;
      case (r_state)
         ARMED: begin
            if (w_take && wreq_i) begin
               w_ack = 1'b1;
               if (w_hit) begin
                  w_fill_we   = 1'b1;
                  w_fill_way  = w_hit_sel;
                  w_fill_idx  = adr_i[OFF_BITS +: IDX_BITS];
                  w_fill_line = w_merge;
                  w_fill_tag  = core_tag_i;
               end
            end else if (w_rd_hit_ack) begin
               w_ack = 1'b1;
               w_q   = w_hit_word;
            end
         end
         WAIT4BIU: begin
            w_stall   = 1'b1;
            w_stb     = 1'b1;
            w_biu_adr = {r_line_adr, {OFF_BITS{1'b0}}};
         end
         FILL: w_stall = 1'b1;
         RECOVER: begin
            w_stall     = 1'b1;
            w_fill_we   = 1'b1;
            w_fill_way  = w_victim;
            w_fill_idx  = r_line_adr[IDX_BITS-1:0];
            w_fill_line = r_buf;
            w_fill_tag  = r_tag;
            w_ack       = w_recover_ack;
            if (w_recover_ack) w_q = r_buf[r_word*XLEN +: XLEN];
         end
         default: w_stall = 1'b0;
      endcase
   end

   // Beats arrive lowest word first; shifting in from the top leaves beat 0 in word 0.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= ARMED;
         r_cnt      <= '0;
         r_word     <= '0;
         r_rr       <= '0;
         r_line_adr <= '0;
         r_tag      <= '0;
         r_valid    <= '0;
         r_buf      <= '0;
         r_flushed  <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            ARMED: begin
               if (w_start_miss) begin
                  r_line_adr <= adr_i[PLEN-1:OFF_BITS];
                  r_word     <= w_word;
                  r_tag      <= core_tag_i;
                  r_valid    <= way_valid_i;
                  r_flushed  <= 1'b0;
               end
            end
            WAIT4BIU: if (flush_i) r_flushed <= 1'b1;
            FILL: begin
               if (flush_i) r_flushed <= 1'b1;
               if (biu_d_ack_i) begin
                  r_buf <= {biu_d_i, r_buf[BLOCK_SIZE-1:XLEN]};
                  r_cnt <= (r_cnt == CNT_BITS'(BURST - 1)) ? '0 : r_cnt + 1'b1;
               end
            end
            RECOVER: r_rr <= (r_rr == PTR_BITS'(WAYS - 1)) ? '0 : r_rr + 1'b1;
            default: r_rr <= r_rr;
         endcase
      end
   end

   assign stall_o     = ~rst_i & w_stall;
   assign ack_o       = ~rst_i & w_ack;
   assign q_o         = rst_i ? '0 : w_q;
   assign biu_stb_o   = ~rst_i & w_stb;
   assign biu_adr_o   = rst_i ? '0 : w_biu_adr;
   assign fill_we_o   = ~rst_i & w_fill_we;
   assign fill_way_o  = rst_i ? '0 : w_fill_way;
   assign fill_idx_o  = rst_i ? '0 : w_fill_idx;
   assign fill_line_o = rst_i ? '0 : w_fill_line;
   assign fill_tag_o  = rst_i ? '0 : w_fill_tag;

`ifdef RISCV_CACHE_PERFCNT_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hit_cnt_o  <= '0;
         miss_cnt_o <= '0;
      end else begin
         if (w_rd_hit_ack)  hit_cnt_o  <= hit_cnt_o + 32'd1;
         if (w_recover_ack) miss_cnt_o <= miss_cnt_o + 32'd1;
      end
   end
`endif

endmodule
